// File: rtl/dptr_pipe_if.sv
// rtl/dptr_pipe_if.sv - instruction, writeback and debug signal bundle for dptr_pipe
interface dptr_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              illegal;
    logic [REG_AW-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output instr_valid, instr, dbg_addr,
        input  instr_ready, wb_valid, wb_addr, wb_data, illegal, dbg_data
    );

    modport slave (
        input  instr_valid, instr, dbg_addr,
        output instr_ready, wb_valid, wb_addr, wb_data, illegal, dbg_data
    );
endinterface

// File: rtl/dptr_pipe.sv
// rtl/dptr_pipe.sv - 3-stage D/X/M pipelined datapath with forwarding and load-use stall
module dptr_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int MEM_AW = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    dptr_pipe_if.slave  bus
);
    localparam int NREG   = 2 ** REG_AW;
    localparam int MDEPTH = 2 ** MEM_AW;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;

    // D stage: raw instruction
    logic              d_valid_q, d_valid_d;
    logic [31:0]       d_instr_q, d_instr_d;
    // X stage: only the fields the ALU needs, plus forwarded operands
    logic              x_valid_q, x_valid_d;
    logic [5:0]        x_op_q, x_op_d;
    logic [REG_AW-1:0] x_rt_q, x_rt_d;
    logic [15:0]       x_imm_q, x_imm_d;
    logic [DATA_W-1:0] x_a_q, x_a_d;
    logic [DATA_W-1:0] x_b_q, x_b_d;
    // M stage: resolved write intent and memory address
    logic              m_valid_q, m_valid_d;
    logic              m_rf_we_q, m_rf_we_d;
    logic              m_is_lw_q, m_is_lw_d;
    logic              m_is_sw_q, m_is_sw_d;
    logic [REG_AW-1:0] m_dst_q, m_dst_d;
    logic [MEM_AW-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_val_q, m_val_d;

    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [DATA_W-1:0] mem_q [MDEPTH];

    logic              x_is_r, x_is_lw, x_is_sw, x_r_ok, x_legal, x_rf_we, x_fwd_en;
    logic [REG_AW-1:0] x_dst;
    logic [DATA_W-1:0] x_alu, x_simm;
    logic [MEM_AW-1:0] x_ea;
    logic              wb_valid_w;
    logic [DATA_W-1:0] wb_data_w;
    logic [5:0]        d_op;
    logic [REG_AW-1:0] d_rs, d_rt;
    logic [DATA_W-1:0] d_a, d_b;
    logic              stall;

    // Operand source selection: X result, then M writeback, then regfile; r0 is hard zero
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_AW-1:0] a,
        input logic              xw, input logic [REG_AW-1:0] xd, input logic [DATA_W-1:0] xv,
        input logic              mw, input logic [REG_AW-1:0] md, input logic [DATA_W-1:0] mv,
        input logic [DATA_W-1:0] rv
    );
        if (a == '0)                 return '0;
        else if (xw && (xd == a))    return xv;
        else if (mw && (md == a))    return mv;
        else                         return rv;
    endfunction

    // X stage decode, ALU and effective address
    always_comb begin
        x_is_r  = (x_op_q == OP_R);
        x_is_lw = (x_op_q == OP_LW);
        x_is_sw = (x_op_q == OP_SW);
        x_simm  = DATA_W'($signed(x_imm_q));
        x_r_ok  = 1'b0;
        x_alu   = '0;
        case (x_imm_q[5:0])
            F_ADD: begin x_r_ok = 1'b1; x_alu = x_a_q + x_b_q; end
            F_SUB: begin x_r_ok = 1'b1; x_alu = x_a_q - x_b_q; end
            F_AND: begin x_r_ok = 1'b1; x_alu = x_a_q & x_b_q; end
            F_OR:  begin x_r_ok = 1'b1; x_alu = x_a_q | x_b_q; end
            F_SLT: begin x_r_ok = 1'b1; x_alu = DATA_W'($signed(x_a_q) < $signed(x_b_q)); end
            F_SLL: begin x_r_ok = 1'b1; x_alu = x_b_q << x_imm_q[10:6]; end
            F_SRL: begin x_r_ok = 1'b1; x_alu = x_b_q >> x_imm_q[10:6]; end
            default: ;
        endcase
        x_ea     = MEM_AW'(x_a_q + x_simm);
        x_legal  = (x_is_r && x_r_ok) || x_is_lw || x_is_sw;
        x_dst    = x_is_r ? x_imm_q[11 +: REG_AW] : x_rt_q;
        x_rf_we  = x_valid_q && x_legal && !x_is_sw && (x_dst != '0);
        x_fwd_en = x_rf_we && !x_is_lw;
    end

    // M stage writeback; load data comes straight out of the memory array
    always_comb begin
        wb_valid_w = m_valid_q && m_rf_we_q;
        wb_data_w  = m_is_lw_q ? mem_q[m_addr_q] : m_val_q;
    end

    // D stage operand read with forwarding and load-use hazard detection
    always_comb begin
        d_op  = d_instr_q[31:26];
        d_rs  = d_instr_q[21 +: REG_AW];
        d_rt  = d_instr_q[16 +: REG_AW];
        d_a   = fwd_sel(d_rs, x_fwd_en, x_dst, x_alu, wb_valid_w, m_dst_q, wb_data_w, rf_q[d_rs]);
        d_b   = fwd_sel(d_rt, x_fwd_en, x_dst, x_alu, wb_valid_w, m_dst_q, wb_data_w, rf_q[d_rt]);
        stall = d_valid_q && x_valid_q && x_is_lw && (x_rt_q != '0) &&
                ((d_rs == x_rt_q) || (((d_op == OP_R) || (d_op == OP_SW)) && (d_rt == x_rt_q)));
    end

    // Pipeline advance: D holds and X takes a bubble while stalled
    always_comb begin
        d_valid_d = d_valid_q;
        d_instr_d = d_instr_q;
        if (!stall) begin
            d_valid_d = bus.instr_valid;
            d_instr_d = bus.instr;
        end
        x_valid_d = d_valid_q && !stall;
        x_op_d    = d_op;
        x_rt_d    = d_rt;
        x_imm_d   = d_instr_q[15:0];
        x_a_d     = d_a;
        x_b_d     = d_b;
        m_valid_d = x_valid_q;
        m_rf_we_d = x_rf_we;
        m_is_lw_d = x_valid_q && x_is_lw;
        m_is_sw_d = x_valid_q && x_is_sw;
        m_dst_d   = x_dst;
        m_addr_d  = x_ea;
        m_val_d   = x_is_sw ? x_b_q : x_alu;
    end

    // Register file update from the M writeback
    always_comb begin
        rf_d = rf_q;
        if (wb_valid_w) rf_d[m_dst_q] = wb_data_w;
    end

    // Stage and regfile state; reset discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid_q <= 1'b0;
            d_instr_q <= '0;
            x_valid_q <= 1'b0;
            x_op_q    <= '0;
            x_rt_q    <= '0;
            x_imm_q   <= '0;
            x_a_q     <= '0;
            x_b_q     <= '0;
            m_valid_q <= 1'b0;
            m_rf_we_q <= 1'b0;
            m_is_lw_q <= 1'b0;
            m_is_sw_q <= 1'b0;
            m_dst_q   <= '0;
            m_addr_q  <= '0;
            m_val_q   <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            d_valid_q <= d_valid_d;
            d_instr_q <= d_instr_d;
            x_valid_q <= x_valid_d;
            x_op_q    <= x_op_d;
            x_rt_q    <= x_rt_d;
            x_imm_q   <= x_imm_d;
            x_a_q     <= x_a_d;
            x_b_q     <= x_b_d;
            m_valid_q <= m_valid_d;
            m_rf_we_q <= m_rf_we_d;
            m_is_lw_q <= m_is_lw_d;
            m_is_sw_q <= m_is_sw_d;
            m_dst_q   <= m_dst_d;
            m_addr_q  <= m_addr_d;
            m_val_q   <= m_val_d;
            rf_q      <= rf_d;
        end
    end

    // Data memory store at the edge that ends M; contents survive reset
    always_ff @(posedge clk) begin
        if (m_is_sw_q) mem_q[m_addr_q] <= m_val_q;
    end

    assign bus.instr_ready = !stall;
    assign bus.wb_valid    = wb_valid_w;
    assign bus.wb_addr     = m_dst_q;
    assign bus.wb_data     = wb_data_w;
    assign bus.illegal     = x_valid_q && !x_legal;
    assign bus.dbg_data    = rf_q[bus.dbg_addr];
endmodule

// File: tb/tb_dptr_pipe.sv
// tb/tb_dptr_pipe.sv - directed self-checking bench for dptr_pipe
module tb_dptr_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dptr_pipe_if #(.DATA_W(32), .REG_AW(5)) bus ();

    dptr_pipe #(.DATA_W(32), .REG_AW(5), .MEM_AW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100, OR_ = 6'b100101;
    localparam logic [5:0] SLT = 6'b101010, SLL = 6'b000000, SRL = 6'b000010;
    localparam logic [5:0] LW  = 6'b100011, SW  = 6'b101011;

    function automatic logic [31:0] r_ins(input logic [5:0] f, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] sh);
        return {6'b000000, rs, rt, rd, sh, f};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        tick();
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".valid"}, 32'(bus.wb_valid), 32'd1);
        chk({tag, ".addr"},  32'(bus.wb_addr),  32'(a));
        chk({tag, ".data"},  bus.wb_data,       d);
    endtask

    task automatic chk_nowb(input string tag);
        chk({tag, ".nowb"}, 32'(bus.wb_valid), 32'd0);
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] v);
        bus.dbg_addr = r;
        #1;
        chk(tag, bus.dbg_data, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.dbg_addr    = 5'd0;
        dut.mem_q[0]    = 32'd5;
        dut.mem_q[1]    = 32'd7;
        dut.mem_q[4]    = 32'h0000_1234;
        dut.mem_q[8]    = 32'h0000_DEAD;

        // power-on reset state
        repeat (3) tick();
        chk("por.ready",   32'(bus.instr_ready), 32'd1);
        chk("por.wbv",     32'(bus.wb_valid),    32'd0);
        chk("por.wba",     32'(bus.wb_addr),     32'd0);
        chk("por.wbd",     bus.wb_data,          32'd0);
        chk("por.illegal", 32'(bus.illegal),     32'd0);
        rst_n = 1'b1;
        tick();

        // preload r1=5, r2=7 through loads
        send(i_ins(LW, 5'd1, 5'd0, 16'd0));
        send(i_ins(LW, 5'd2, 5'd0, 16'd1));
        repeat (3) tick();
        chk_reg("pre.r1", 5'd1, 32'd5);
        chk_reg("pre.r2", 5'd2, 32'd7);
        tick();

        // add / sub / slt, each retiring two cycles after acceptance
        send(r_ins(ADD, 5'd3, 5'd1, 5'd2, 5'd0));
        chk_nowb("t2.c0");
        send(r_ins(SUB, 5'd4, 5'd1, 5'd2, 5'd0));
        chk_nowb("t2.c1");
        send(r_ins(SLT, 5'd5, 5'd1, 5'd2, 5'd0));
        chk_wb("t2.add", 5'd3, 32'd12);
        tick();
        chk_wb("t2.sub", 5'd4, 32'hFFFF_FFFE);
        tick();
        chk_wb("t2.slt", 5'd5, 32'd1);
        tick();
        chk_nowb("t2.end");
        chk_reg("t2.r4", 5'd4, 32'hFFFF_FFFE);
        tick();

        // back-to-back dependences resolved by forwarding, no stalls
        chk("t3.rdy0", 32'(bus.instr_ready), 32'd1);
        send(r_ins(ADD, 5'd3, 5'd1, 5'd2, 5'd0));
        chk("t3.rdy1", 32'(bus.instr_ready), 32'd1);
        send(r_ins(ADD, 5'd4, 5'd3, 5'd3, 5'd0));
        chk("t3.rdy2", 32'(bus.instr_ready), 32'd1);
        send(r_ins(OR_, 5'd5, 5'd4, 5'd1, 5'd0));
        chk_wb("t3.r3", 5'd3, 32'd12);
        tick();
        chk_wb("t3.r4", 5'd4, 32'd24);
        tick();
        chk_wb("t3.r5", 5'd5, 32'd29);
        tick();
        chk_reg("t3.dbg_r5", 5'd5, 32'd29);
        tick();

        // shifts and and
        send(r_ins(SLL,  5'd13, 5'd0, 5'd2, 5'd4));
        send(r_ins(SRL,  5'd14, 5'd0, 5'd4, 5'd3));
        send(r_ins(AND_, 5'd15, 5'd1, 5'd2, 5'd0));
        chk_wb("sh.sll", 5'd13, 32'h70);
        tick();
        chk_wb("sh.srl", 5'd14, 32'd3);
        tick();
        chk_wb("sh.and", 5'd15, 32'd5);
        tick();

        // load-use: one stall cycle, then forwarded load data
        chk("t4.rdy0", 32'(bus.instr_ready), 32'd1);
        send(i_ins(LW, 5'd6, 5'd0, 16'd4));
        bus.instr_valid = 1'b1;
        bus.instr       = r_ins(ADD, 5'd7, 5'd6, 5'd6, 5'd0);
        chk("t4.rdy1", 32'(bus.instr_ready), 32'd1);
        tick();
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        chk("t4.stall", 32'(bus.instr_ready), 32'd0);
        tick();
        chk("t4.rdy2", 32'(bus.instr_ready), 32'd1);
        chk_wb("t4.lw", 5'd6, 32'h1234);
        tick();
        chk("t4.rdy3", 32'(bus.instr_ready), 32'd1);
        chk_nowb("t4.bubble");
        tick();
        chk_wb("t4.add", 5'd7, 32'h2468);
        tick();

        // sw then lw at the same address, and a dropped write to r0
        send(i_ins(SW, 5'd1, 5'd0, 16'd8));
        send(i_ins(LW, 5'd8, 5'd0, 16'd8));
        tick();
        chk_nowb("t5.sw");
        tick();
        chk_wb("t5.lw", 5'd8, 32'd5);
        tick();
        send(r_ins(ADD, 5'd0, 5'd1, 5'd1, 5'd0));
        chk_nowb("t5.r0a");
        tick();
        chk_nowb("t5.r0b");
        tick();
        chk_nowb("t5.r0c");
        tick();
        chk_reg("t5.dbg_r0", 5'd0, 32'd0);
        chk_reg("t5.dbg_r8", 5'd8, 32'd5);
        tick();

        // illegal opcode, illegal funct, then a normal add
        send({6'b111111, 26'd0});
        chk("t6.ill0", 32'(bus.illegal), 32'd0);
        send(r_ins(6'b111111, 5'd9, 5'd1, 5'd2, 5'd0));
        chk("t6.ill1", 32'(bus.illegal), 32'd1);
        send(r_ins(ADD, 5'd9, 5'd1, 5'd2, 5'd0));
        chk("t6.ill2", 32'(bus.illegal), 32'd1);
        chk_nowb("t6.m1");
        tick();
        chk("t6.ill3", 32'(bus.illegal), 32'd0);
        chk_nowb("t6.m2");
        tick();
        chk("t6.ill4", 32'(bus.illegal), 32'd0);
        chk_wb("t6.add", 5'd9, 32'd12);
        tick();

        // reset with three instructions in flight
        send(r_ins(ADD, 5'd10, 5'd1, 5'd2, 5'd0));
        send(r_ins(ADD, 5'd11, 5'd1, 5'd1, 5'd0));
        send(r_ins(ADD, 5'd12, 5'd2, 5'd2, 5'd0));
        chk_wb("t1.inflight", 5'd10, 32'd12);
        rst_n = 1'b0;
        #1;
        chk("t1.ready",   32'(bus.instr_ready), 32'd1);
        chk("t1.wbv",     32'(bus.wb_valid),    32'd0);
        chk("t1.wba",     32'(bus.wb_addr),     32'd0);
        chk("t1.wbd",     bus.wb_data,          32'd0);
        chk("t1.illegal", 32'(bus.illegal),     32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_nowb($sformatf("t1.post%0d", c));
        end
        for (int r = 0; r < 32; r++) chk_reg($sformatf("t1.r%0d", r), 5'(r), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
